// File: rtl/alu_pkg.sv
// Shared widths and opcode encodings for the integer execute stage.
package alu_pkg;
  localparam int XLEN = 64;
  localparam int RD_W = 5;
  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd2;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd3;
  localparam logic [OP_W-1:0] OP_AND  = 4'd4;
  localparam logic [OP_W-1:0] OP_OR   = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd7;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd8;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd9;
endpackage

// File: rtl/add_sub_64bit.sv
// 64-bit adder/subtractor, combinational; mode=1 computes a-b as a+~b+1.
module add_sub_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        mode,
  output logic [63:0] sum
);
  assign sum = a + (b ^ {64{mode}}) + {63'd0, mode};
endmodule

// File: rtl/alu_core_64.sv
// Combinational ALU: (op, a, b) -> (result, illegal); zero latency, no flow control.
module alu_core_64 import alu_pkg::*; (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  logic [XLEN-1:0] sum;
  logic            lt_s;
  logic            lt_u;
  logic [5:0]      shamt;
  logic            is_sub;

  assign is_sub = (op == OP_SUB);
  assign shamt  = b[5:0];

  add_sub_64bit u_add_sub (
    .a    (a),
    .b    (b),
    .mode (is_sub),
    .sum  (sum)
  );

  strictly_less_than_s u_lt_s (
    .a  (a),
    .b  (b),
    .lt (lt_s)
  );

  strictly_less_than_uns u_lt_u (
    .a  (a),
    .b  (b),
    .lt (lt_u)
  );

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD, OP_SUB: result = sum;
      OP_SLT:         result = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU:        result = {{(XLEN-1){1'b0}}, lt_u};
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_SLL:         result = a << shamt;
      OP_SRL:         result = a >> shamt;
      OP_SRA:         result = $unsigned($signed(a) >>> shamt);
      default:        illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/strictly_less_than_s.sv
// Signed a<b, combinational; differing signs decide directly, so no overflow case remains.
module strictly_less_than_s (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        lt
);
  assign lt = (a[63] ^ b[63]) ? a[63] : (a[62:0] < b[62:0]);
endmodule

// File: rtl/strictly_less_than_uns.sv
// Unsigned a<b, combinational.
module strictly_less_than_uns (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        lt
);
  assign lt = (a < b);
endmodule

// File: rtl/alu_ex_stage.sv
// Registered ALU execute stage: 1-cycle latency, valid/ready out with a one-entry skid.
// in_ready depends only on skid occupancy and rst, so full throughput holds under backpressure.
module alu_ex_stage import alu_pkg::*; #(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int RD_W = alu_pkg::RD_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);
  logic [XLEN-1:0] core_res;
  logic            core_ill;
  logic [XLEN-1:0] new_res;
  logic            accept;
  logic            drain;

  logic            out_vld_q,  out_vld_d;
  logic [XLEN-1:0] out_res_q,  out_res_d;
  logic [RD_W-1:0] out_rd_q,   out_rd_d;
  logic            out_ill_q,  out_ill_d;
  logic            skid_vld_q, skid_vld_d;
  logic [XLEN-1:0] skid_res_q, skid_res_d;
  logic [RD_W-1:0] skid_rd_q,  skid_rd_d;
  logic            skid_ill_q, skid_ill_d;

  alu_core_64 u_core (
    .op      (in_op),
    .a       (in_a),
    .b       (in_b),
    .result  (core_res),
    .illegal (core_ill)
  );

  assign new_res  = (in_rd == '0) ? '0 : core_res;
  assign in_ready = !rst && !skid_vld_q;
  assign accept   = in_valid && in_ready;
  assign drain    = out_vld_q && out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_res_d  = out_res_q;
    out_rd_d   = out_rd_q;
    out_ill_d  = out_ill_q;
    skid_vld_d = skid_vld_q;
    skid_res_d = skid_res_q;
    skid_rd_d  = skid_rd_q;
    skid_ill_d = skid_ill_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q) begin
      if (accept) begin
        out_vld_d = 1'b1;
        out_res_d = new_res;
        out_rd_d  = in_rd;
        out_ill_d = core_ill;
      end
    end else if (!skid_vld_q) begin
      if (accept && drain) begin
        out_res_d = new_res;
        out_rd_d  = in_rd;
        out_ill_d = core_ill;
      end else if (accept) begin
        skid_vld_d = 1'b1;
        skid_res_d = new_res;
        skid_rd_d  = in_rd;
        skid_ill_d = core_ill;
      end else if (drain) begin
        out_vld_d = 1'b0;
      end
    end else if (drain) begin
      // FULL: the older skid entry moves up; in_ready is low so nothing new arrives.
      out_res_d  = skid_res_q;
      out_rd_d   = skid_rd_q;
      out_ill_d  = skid_ill_q;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_res_q  <= '0;
      out_rd_q   <= '0;
      out_ill_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_res_q <= '0;
      skid_rd_q  <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_res_q  <= out_res_d;
      out_rd_q   <= out_rd_d;
      out_ill_q  <= out_ill_d;
      skid_vld_q <= skid_vld_d;
      skid_res_q <= skid_res_d;
      skid_rd_q  <= skid_rd_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign out_valid   = out_vld_q;
  assign out_result  = out_res_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_ill_q;
endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
Registered execute stage of the integer pipeline. It sits between decode/issue (upstream) and writeback (downstream). It accepts one decoded ALU op per cycle, computes the 64-bit result, and presents it through a valid/ready output with a one-entry skid buffer, so throughput is one op per cycle under backpressure. The arithmetic core reuses the existing add_sub_64bit, strictly_less_than_s and strictly_less_than_uns blocks.

Parameters:
XLEN, 64, datapath width; fixed at 64 to match the arithmetic sub-blocks.
RD_W, 5, destination register index width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  upstream offers an op.
in_ready  output  1  stage can accept this cycle.
in_op  input  4  opcode, encoded per alu_pkg.
in_a  input  64  operand A.
in_b  input  64  operand B.
in_rd  input  RD_W  destination register.
flush  input  1  synchronous pipeline kill.
out_valid  output  1  result available.
out_ready  input  1  writeback consumes this cycle.
out_result  output  64  computed result.
out_rd  output  RD_W  destination register of the result.
out_illegal  output  1  op was an undefined encoding.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10-15 illegal.
- SLT and SLTU return 0 or 1 in bit 0, with bits 63:1 zero. SLT is overflow-corrected signed compare.
- Shifts use in_b[5:0]. SRA sign-fills. ADD and SUB wrap modulo 2^64.
- Illegal op: result 0, out_illegal=1. The entry still flows through normally.
- in_rd==0: the stored result is forced to 0. out_illegal is unaffected.
- Storage: an OUT register and a SKID register, each with a valid bit.
- States: EMPTY (neither valid), ONE (OUT valid), FULL (OUT and SKID valid).
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- in_ready = !rst && !skid_valid. It is low in FULL and while rst is high.
- EMPTY: accept -> ONE; otherwise stay.
- ONE:
  - accept && drain -> ONE, with OUT replaced by the new op.
  - accept && !drain -> FULL, with the new op written to SKID.
  - !accept && drain -> EMPTY.
  - otherwise hold.
- FULL: drain -> ONE, with SKID moved into OUT and SKID invalidated; otherwise hold. No accept is possible in FULL.
- Latency: an op accepted at edge N is visible on out_* after edge N (1 cycle) when the stage was EMPTY, or when ONE with drain in the same cycle.
- Ordering is strict FIFO. No op is dropped or duplicated except by flush or rst.
- While out_valid && !out_ready, out_result, out_rd and out_illegal are held stable.
- flush: next state is EMPTY and both valid bits clear. An op presented in the flush cycle is discarded. Priority is rst > flush > normal operation.
- Reset: out_valid=0, out_result=0, out_rd=0, out_illegal=0, skid_valid=0. Reset asserted mid-stream discards all held ops.
- Data registers update only on capture. Valid bits alone carry state.

Decomposition:
- alu_pkg: XLEN, RD_W defaults and the opcode localparams (OP_ADD..OP_SRA), plus the op-width constant.
- Sub-module alu_core_64: purely combinational, (op, a, b) -> (result, illegal).
  - Instantiates add_sub_64bit (mode=1 for SUB), strictly_less_than_s and strictly_less_than_uns.
  - Contains the logic and shift functions.
- alu_ex_stage holds only the handshake, skid buffer, rd==0 forcing and flush logic.

Test Plan:
1. Reset, then SLT a=0xFFFF_FFFF_FFFF_FFFF b=1 -> out_result=1 one cycle later. SLTU with the same operands -> 0. SUB 3-5 -> 0xFFFF_FFFF_FFFF_FFFE.
2. Overflow compares:
   - SLT a=0x8000_0000_0000_0000 b=1 -> 1.
   - SLT a=0x7FFF_FFFF_FFFF_FFFF b=0xFFFF_FFFF_FFFF_FFFF -> 0.
   - SLTU a=0 b=0 -> 0.
3. Backpressure: hold out_ready=0 and offer ADDs 1+1, 2+2, 3+3 back-to-back.
   - First two are accepted; in_ready drops; the third is held upstream.
   - Raise out_ready: results 2, 4, 6 emerge in order, one per cycle, with no duplicates.
4. Streaming: out_ready=1 with 8 consecutive ops -> in_ready stays 1, out_valid is high for 8 consecutive cycles, and each result matches a reference model.
5. Flush in FULL with in_valid=1 on the same cycle -> next cycle out_valid=0 and in_ready=1, and the flushed-cycle op never appears. rst asserted in ONE -> out_valid=0, out_result=0.
6. Edge ops:
   - ADD 5+7 with rd=0 -> out_result=0.
   - Opcode 12 -> out_illegal=1, out_result=0.
   - SRA 0x8000_0000_0000_0000 by 63 -> 0xFFFF_FFFF_FFFF_FFFF.
   - SLL 1 by 64 (b=64, so shift amount is 0) -> 1.
